// File: rtl/mf_pkg.sv
// mf_pkg: shared coefficient type, pipeline latency, reset coefficient set and accumulator sizing
package mf_pkg;
  typedef logic signed [3:0] coef_t;
  localparam int MF_LAT = 3;
  // [0][k] = cA[k], [1][k] = cB[k]: cA = 1,1,1,2,-2  cB = 0,-1,-1,-1,-4
  localparam coef_t [1:0][4:0] SYSTB_COEFS = {4'hC, 4'hF, 4'hF, 4'hF, 4'h0,
                                              4'hE, 4'h2, 4'h1, 4'h1, 4'h1};
  function automatic int mf_acc_bits(input int inbits, input int ntap, input int outbits);
    int w;
    w = inbits + 4 + $clog2(2 * ntap);
    return (w > outbits ? w : outbits) + 1;
  endfunction
endpackage

// File: rtl/mf_lane.sv
// mf_lane: one output lane - S2 tap products and partial sum, S3 addend, narrowing, output register.
// `MF_SAT_EN selects saturating narrowing; otherwise the low OUTBITS bits are kept.
module mf_lane
  import mf_pkg::*;
#(
  parameter int INBITS  = 12,
  parameter int NTAP    = 5,
  parameter int OUTBITS = 16,
  parameter int ACCBITS = 21
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en2,
  input  logic                          en3,
  input  logic [NTAP-1:0][INBITS-1:0]   a,
  input  logic [NTAP-1:0][INBITS-1:0]   b,
  input  coef_t [2*NTAP-1:0]            coef,
  input  logic [OUTBITS-1:0]            add,
  output logic [OUTBITS-1:0]            out,
  output logic                          sat
);
  logic signed [ACCBITS-1:0] psum, psum2, add2, tot;
  logic [OUTBITS-1:0] nar;
  logic clip;
  always_comb begin
    psum = '0;
    for (int k = 0; k < NTAP; k++)
      psum = psum + ACCBITS'($signed(a[k])) * ACCBITS'($signed(coef[k]))
                  + ACCBITS'($signed(b[k])) * ACCBITS'($signed(coef[NTAP+k]));
  end
  assign tot = psum2 + add2;
`ifdef MF_SAT_EN
  localparam logic signed [ACCBITS-1:0] MAXV = ACCBITS'((1 << (OUTBITS - 1)) - 1);
  localparam logic signed [ACCBITS-1:0] MINV = ~MAXV;
  always_comb begin
    clip = (tot > MAXV) || (tot < MINV);
    nar  = tot > MAXV ? MAXV[OUTBITS-1:0] : tot < MINV ? MINV[OUTBITS-1:0] : tot[OUTBITS-1:0];
  end
`else
  logic unused_hi;
  assign unused_hi = ^tot[ACCBITS-1:OUTBITS];
  assign clip = 1'b0;
  assign nar  = tot[OUTBITS-1:0];
`endif
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      psum2 <= '0;
      add2  <= '0;
      out   <= '0;
      sat   <= 1'b0;
    end else begin
      if (en2) begin
        psum2 <= psum;
        add2  <= ACCBITS'($signed(add));
      end
      if (en3) begin
        out <= nar;
        sat <= clip;
      end
    end
endmodule

// File: rtl/systolic_mf_gen.sv
// systolic_mf_gen: NLANE-wide runtime-programmable A/B matched filter with MF_LAT-clock latency.
// Optional `MF_SAT_EN makes the output narrowing saturate and drive sat_o.
module systolic_mf_gen
  import mf_pkg::*;
#(
  parameter int INBITS  = 12,
  parameter int NLANE   = 2,
  parameter int NTAP    = 5,
  parameter int OUTBITS = INBITS + 4,
  parameter coef_t [1:0][NTAP-1:0] COEF_INIT = SYSTB_COEFS
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  input  logic [NLANE*INBITS-1:0]      inA_i,
  input  logic [NLANE*INBITS-1:0]      inB_i,
  input  logic [NLANE*OUTBITS-1:0]     add_i,
  input  logic                         coef_wr_i,
  input  logic [$clog2(2*NTAP)-1:0]    coef_idx_i,
  input  logic [3:0]                   coef_dat_i,
  input  logic                         coef_commit_i,
  output logic                         valid_o,
  output logic [NLANE*OUTBITS-1:0]     out_o,
  output logic [NLANE-1:0]             sat_o
);
  localparam int ACCBITS = mf_acc_bits(INBITS, NTAP, OUTBITS);
  localparam int HD      = (NTAP + NLANE - 2) / NLANE;
  localparam int WIN     = (HD + 1) * NLANE;
  coef_t [2*NTAP-1:0] shadow, shadow_nxt, active, coef1;
  logic [WIN-1:0][INBITS-1:0] win_a, win_b;
  logic [NLANE*OUTBITS-1:0] add1;
  logic [MF_LAT-1:0] vp;
  always_comb begin
    shadow_nxt = shadow;
    if (coef_wr_i && 32'(coef_idx_i) < 2 * NTAP) shadow_nxt[coef_idx_i] = coef_dat_i;
  end
  // Coefficients travel with their sample from S1 on, so a commit never touches in-flight data
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      shadow <= COEF_INIT;
      active <= COEF_INIT;
      coef1  <= COEF_INIT;
      win_a  <= '0;
      win_b  <= '0;
      add1   <= '0;
      vp     <= '0;
    end else begin
      shadow <= shadow_nxt;
      if (coef_commit_i) active <= shadow_nxt;
      vp <= {vp[MF_LAT-2:0], valid_i};
      if (valid_i) begin
        win_a <= {inA_i, win_a[WIN-1:NLANE]};
        win_b <= {inB_i, win_b[WIN-1:NLANE]};
        add1  <= add_i;
        coef1 <= active;
      end
    end
  assign valid_o = vp[MF_LAT-1];
  for (genvar l = 0; l < NLANE; l++) begin : g_lane
    logic [NTAP-1:0][INBITS-1:0] ta, tb;
    for (genvar k = 0; k < NTAP; k++) begin : g_tap
      assign ta[k] = win_a[HD*NLANE+l-k];
      assign tb[k] = win_b[HD*NLANE+l-k];
    end
    mf_lane #(
      .INBITS(INBITS), .NTAP(NTAP), .OUTBITS(OUTBITS), .ACCBITS(ACCBITS)
    ) u_lane (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .en2(vp[0]),
      .en3(vp[1]),
      .a(ta),
      .b(tb),
      .coef(coef1),
      .add(add1[l*OUTBITS +: OUTBITS]),
      .out(out_o[l*OUTBITS +: OUTBITS]),
      .sat(sat_o[l])
    );
  end
endmodule

// File: tb/tb_systolic_mf_gen.sv
// tb_systolic_mf_gen: directed vector table plus hand-written coefficient-commit and mid-stream reset sequences.
module tb_systolic_mf_gen;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, wr = 1'b0, commit = 1'b0;
  logic [23:0] a_in = '0, b_in = '0;
  logic [31:0] add_in = '0;
  logic [3:0] idx = '0, dat = '0;
  logic valid_o;
  logic [31:0] out;
  logic [1:0] sat;
  int n_tests = 0, n_fail = 0;
  typedef struct {
    logic v;
    int a0, a1, b0, b1, ad;
    logic ev;
    int e0, e1;
  } vec_t;
  vec_t vecs[$];
  logic [63:0] cap[$];
  systolic_mf_gen dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .inA_i(a_in), .inB_i(b_in), .add_i(add_in),
    .coef_wr_i(wr), .coef_idx_i(idx), .coef_dat_i(dat), .coef_commit_i(commit),
    .valid_o(valid_o), .out_o(out), .sat_o(sat)
  );
  always #5 clk = ~clk;
  function automatic logic [16:0] nar(input int f);
`ifdef MF_SAT_EN
    if (f > 32767) return {1'b1, 16'h7fff};
    if (f < -32768) return {1'b1, 16'h8000};
`endif
    return {1'b0, f[15:0]};
  endfunction
  function automatic logic [63:0] pack_exp(input logic ev, input int e0, input int e1);
    logic [16:0] n0, n1;
    n0 = nar(e0);
    n1 = nar(e1);
    return 64'({ev, n1[16], n0[16], n1[15:0], n0[15:0]});
  endfunction
  function automatic logic [63:0] act();
    return 64'({valid_o, sat, out});
  endfunction
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic drive(input logic v, input int a0, input int a1, input int b0, input int b1, input int ad);
    valid  = v;
    a_in   = {12'(a1), 12'(a0)};
    b_in   = {12'(b1), 12'(b0)};
    add_in = {16'(ad), 16'(ad)};
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic tick_cap();
    tick();
    if (valid_o) cap.push_back(act());
  endtask
  task automatic add_v(input logic v, input int a0, input int a1, input int b0, input int b1,
                       input int ad, input logic ev, input int e0, input int e1);
    vecs.push_back('{v, a0, a1, b0, b1, ad, ev, e0, e1});
  endtask
  task automatic junk(input logic ev, input int e0, input int e1);
    add_v(1'b0, 999, -999, 555, -555, 1234, ev, e0, e1);
  endtask
  task automatic check_cap(input string nm, input int n, input int e[10]);
    chk({nm, "_count"}, 64'(cap.size()), 64'(n));
    for (int j = 0; j < n && j < cap.size(); j++)
      chk($sformatf("%s_out%0d", nm, j), cap[j], pack_exp(1'b1, e[2*j], e[2*j+1]));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    // impulse on A, impulse on B, A impulse with 1- and 4-clock bubbles, saturating constant
    add_v(1'b1, 100, 0, 0, 0, 0, 1'b0, 0, 0);
    add_v(1'b1, 0, 0, 0, 0, 0, 1'b0, 0, 0);
    add_v(1'b1, 0, 0, 0, 0, 0, 1'b1, 100, 100);
    add_v(1'b1, 0, 0, 0, 0, 0, 1'b1, 100, 200);
    add_v(1'b1, 0, 0, 0, 0, 0, 1'b1, -200, 0);
    add_v(1'b1, 0, 0, 100, 0, 0, 1'b1, 0, 0);
    add_v(1'b1, 0, 0, 0, 0, 0, 1'b1, 0, 0);
    add_v(1'b1, 0, 0, 0, 0, 0, 1'b1, 0, -100);
    add_v(1'b1, 0, 0, 0, 0, 0, 1'b1, -100, -100);
    add_v(1'b1, 0, 0, 0, 0, 0, 1'b1, -400, 0);
    add_v(1'b1, 100, 0, 0, 0, 0, 1'b1, 0, 0);
    junk(1'b1, 0, 0);
    add_v(1'b1, 0, 0, 0, 0, 0, 1'b1, 100, 100);
    junk(1'b0, 100, 100);
    junk(1'b1, 100, 200);
    junk(1'b0, 100, 200);
    junk(1'b0, 100, 200);
    add_v(1'b1, 0, 0, 0, 0, 0, 1'b0, 100, 200);
    junk(1'b0, 100, 200);
    junk(1'b1, -200, 0);
    add_v(1'b1, 2047, 2047, -2048, -2048, 30000, 1'b0, -200, 0);
    add_v(1'b1, 2047, 2047, -2048, -2048, 30000, 1'b0, -200, 0);
    add_v(1'b1, 2047, 2047, -2048, -2048, 30000, 1'b1, 32047, 36142);
    add_v(1'b1, 2047, 2047, -2048, -2048, 30000, 1'b1, 40237, 46379);
    add_v(1'b1, 2047, 2047, -2048, -2048, 30000, 1'b1, 50477, 50477);
    junk(1'b1, 50477, 50477);
    junk(1'b1, 50477, 50477);
    junk(1'b0, 50477, 50477);
    drive(1'b0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("reset_state", act(), 64'd0);
    rst = 1'b0;
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].a0, vecs[i].a1, vecs[i].b0, vecs[i].b1, vecs[i].ad);
      tick();
      chk($sformatf("vec%0d", i), act(), pack_exp(vecs[i].ev, vecs[i].e0, vecs[i].e1));
    end
    // coefficient update: last write and commit share a clock with a sample that keeps the old set
    rst = 1'b1;
    drive(1'b0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    cap.delete();
    wr = 1'b1;
    idx = 4'd15;
    dat = 4'd7;
    tick_cap();
    idx = 4'd0;
    tick_cap();
    idx = 4'd1;
    dat = 4'd0;
    drive(1'b1, 10, 10, 0, 0, 0);
    tick_cap();
    idx = 4'd2;
    drive(1'b0, 0, 0, 0, 0, 0);
    tick_cap();
    idx = 4'd3;
    tick_cap();
    idx = 4'd4;
    commit = 1'b1;
    drive(1'b1, 10, 10, 0, 0, 0);
    tick_cap();
    wr = 1'b0;
    commit = 1'b0;
    repeat (2) tick_cap();
    drive(1'b0, 0, 0, 0, 0, 0);
    repeat (6) tick_cap();
    check_cap("commit", 4, '{10, 20, 30, 50, 70, 70, 70, 70, 0, 0});
    // asynchronous reset while streaming, then the impulse must see SYSTB coefficients again
    drive(1'b1, 50, 50, 0, 0, 0);
    repeat (4) tick();
    chk("prerst_valid", 64'(valid_o), 64'd1);
    #2 rst = 1'b1;
    #1 chk("async_rst", act(), 64'd0);
    drive(1'b0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    cap.delete();
    drive(1'b1, 100, 0, 0, 0, 0);
    tick_cap();
    drive(1'b1, 0, 0, 0, 0, 0);
    repeat (4) tick_cap();
    drive(1'b0, 0, 0, 0, 0, 0);
    repeat (6) tick_cap();
    check_cap("post_rst", 5, '{100, 100, 100, 200, -200, 0, 0, 0, 0, 0});
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
